// File: rtl/rand_request_scheduler_pkg.sv
// Shared types, default sizing and the round-robin pick helper for rand_request_scheduler.
package rand_sched_pkg;

    localparam int unsigned DEF_NREQ   = 32'd4;
    localparam int unsigned DEF_WIDTH  = 32'd3;
    localparam int unsigned DEF_SETTLE = 32'd3;
    localparam int unsigned MAX_NREQ   = 32'd8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } sched_state_e;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // First set bit of req_vec at or after ptr, wrapping modulo nreq.
    function automatic rr_pick_t rr_pick(input logic [MAX_NREQ-1:0] req_vec,
                                         input logic [2:0]          ptr,
                                         input int unsigned         nreq);
        rr_pick_t    res;
        int unsigned pos;
        logic        hit;
        res.found = 1'b0;
        res.idx   = 3'd0;
        for (int unsigned i = 32'd0; i < MAX_NREQ; i++) begin
            pos       = (32'(ptr) + i) % nreq;
            hit       = (i < nreq) && req_vec[pos[2:0]] && !res.found;
            res.idx   = hit ? pos[2:0] : res.idx;
            res.found = res.found | hit;
        end
        return res;
    endfunction

endpackage

// File: rtl/rand_request_scheduler_frame_tick_settle.sv
// Registers frame_clk, detects its rising edge and delays the pulse until the
// generator output has settled.
module frame_tick_settle
    import rand_sched_pkg::*;
#(
    parameter int unsigned SETTLE = DEF_SETTLE
) (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic fresh_evt
);

    logic frame_q_r;
    logic frame_prev_r;
    logic edge_s;

    // Sample frame_clk into Clk domain and keep one cycle of history.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_q_r    <= 1'b0;
            frame_prev_r <= 1'b0;
        end else begin
            frame_q_r    <= frame_clk;
            frame_prev_r <= frame_q_r;
        end
    end

    assign edge_s = frame_q_r & ~frame_prev_r;

    if (SETTLE == 32'd0) begin : g_no_settle
        assign fresh_evt = edge_s;
    end else if (SETTLE == 32'd1) begin : g_settle_one
        logic dly_r;
        // Single-stage settle delay.
        always_ff @(posedge Clk) begin
            if (Reset) begin
                dly_r <= 1'b0;
            end else begin
                dly_r <= edge_s;
            end
        end
        assign fresh_evt = dly_r;
    end else begin : g_settle_multi
        logic [SETTLE-1:0] dly_r;
        // Shift the edge pulse through the settle delay line.
        always_ff @(posedge Clk) begin
            if (Reset) begin
                dly_r <= '0;
            end else begin
                dly_r <= {dly_r[SETTLE-2:0], edge_s};
            end
        end
        assign fresh_evt = dly_r[SETTLE-1];
    end

endmodule

// File: rtl/rand_request_scheduler.sv
// Hands each frame's random value to at most one requester, round-robin, with a
// grant/ack handshake. Optional RAND_SCHED_WHITEN_EN XORs a free-running counter in.
module rand_request_scheduler
    import rand_sched_pkg::*;
#(
    parameter int unsigned NREQ   = DEF_NREQ,
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned SETTLE = DEF_SETTLE
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_clk,
    input  logic [WIDTH-1:0] randnum,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  ack,
    output logic [NREQ-1:0]  gnt,
    output logic             rand_valid,
    output logic [WIDTH-1:0] rand_data,
    output logic             overrun
);

    localparam int unsigned PTR_W = (NREQ > 32'd1) ? $clog2(NREQ) : 32'd1;

    logic             fresh_evt_s;
    sched_state_e     state_r,   state_nxt_s;
    logic             fresh_r,   fresh_nxt_s;
    logic [PTR_W-1:0] ptr_r,     ptr_nxt_s;
    logic [PTR_W-1:0] win_r,     win_nxt_s;
    logic [NREQ-1:0]  gnt_r,     gnt_nxt_s;
    logic             valid_r,   valid_nxt_s;
    logic [WIDTH-1:0] data_r,    data_nxt_s;
    logic             overrun_r, overrun_nxt_s;
    logic [WIDTH-1:0] latch_val_s;
    rr_pick_t         pick_s;

    frame_tick_settle #(
        .SETTLE    (SETTLE)
    ) u_settle (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .fresh_evt (fresh_evt_s)
    );

`ifdef RAND_SCHED_WHITEN_EN
    logic [WIDTH-1:0] whiten_cnt_r;

    // Free-running whitening counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            whiten_cnt_r <= '0;
        end else begin
            whiten_cnt_r <= whiten_cnt_r + WIDTH'(1);
        end
    end

    assign latch_val_s = randnum ^ whiten_cnt_r;
`else
    assign latch_val_s = randnum;
`endif

    assign pick_s = rr_pick(MAX_NREQ'(req), 3'(ptr_r), NREQ);

    // Next-state, grant and fresh-flag logic; a new fresh_evt overrides the latch clear.
    always_comb begin
        state_nxt_s   = state_r;
        fresh_nxt_s   = fresh_r;
        ptr_nxt_s     = ptr_r;
        win_nxt_s     = win_r;
        gnt_nxt_s     = gnt_r;
        valid_nxt_s   = valid_r;
        data_nxt_s    = data_r;
        overrun_nxt_s = fresh_evt_s & fresh_r;
        case (state_r)
            IDLE: begin
                gnt_nxt_s   = '0;
                valid_nxt_s = 1'b0;
                if (fresh_r && pick_s.found) begin
                    win_nxt_s   = pick_s.idx[PTR_W-1:0];
                    data_nxt_s  = latch_val_s;
                    gnt_nxt_s   = NREQ'(1) << pick_s.idx;
                    valid_nxt_s = 1'b1;
                    fresh_nxt_s = 1'b0;
                    state_nxt_s = OFFER;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            OFFER: begin
                // Ack and abandon both retire the value; only the winner's bits matter.
                if (ack[win_r] || !req[win_r]) begin
                    ptr_nxt_s   = (win_r == PTR_W'(NREQ - 32'd1)) ? '0 : win_r + PTR_W'(1);
                    gnt_nxt_s   = '0;
                    valid_nxt_s = 1'b0;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = OFFER;
                end
            end
            default: begin
                gnt_nxt_s   = '0;
                valid_nxt_s = 1'b0;
                state_nxt_s = IDLE;
            end
        endcase
        fresh_nxt_s = fresh_nxt_s | fresh_evt_s;
    end

    // Scheduler state and registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r   <= IDLE;
            fresh_r   <= 1'b0;
            ptr_r     <= '0;
            win_r     <= '0;
            gnt_r     <= '0;
            valid_r   <= 1'b0;
            data_r    <= '0;
            overrun_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            fresh_r   <= fresh_nxt_s;
            ptr_r     <= ptr_nxt_s;
            win_r     <= win_nxt_s;
            gnt_r     <= gnt_nxt_s;
            valid_r   <= valid_nxt_s;
            data_r    <= data_nxt_s;
            overrun_r <= overrun_nxt_s;
        end
    end

    assign gnt        = gnt_r;
    assign rand_valid = valid_r;
    assign rand_data  = data_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_rand_request_scheduler.sv
// Directed plus randomized bench for rand_request_scheduler against a transaction-level model.
module tb_rand_request_scheduler;

    localparam int NREQ   = 4;
    localparam int WIDTH  = 3;
    localparam int SETTLE = 3;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             frame_clk;
    logic [WIDTH-1:0] randnum;
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  ack;
    logic [NREQ-1:0]  gnt;
    logic             rand_valid;
    logic [WIDTH-1:0] rand_data;
    logic             overrun;

    always #5 Clk = ~Clk;

    rand_request_scheduler #(
        .NREQ       (NREQ),
        .WIDTH      (WIDTH),
        .SETTLE     (SETTLE)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .randnum    (randnum),
        .req        (req),
        .ack        (ack),
        .gnt        (gnt),
        .rand_valid (rand_valid),
        .rand_data  (rand_data),
        .overrun    (overrun)
    );

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // Reference model: one pending value, one open offer, a pointer, and a list
    // of cycles at which settled frame edges become usable.
    bit               m_offer, m_fresh, m_prev_fc, m_ovr;
    int               m_ptr, m_win, m_cycle;
    logic [WIDTH-1:0] m_data, m_cnt;
    int               evt_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int first_from(input int p, input logic [NREQ-1:0] r);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_step();
        bit evt;
        int w;
        m_cycle++;
        if (Reset) begin
            m_offer = 0; m_fresh = 0; m_ptr = 0; m_ovr = 0; m_prev_fc = 0;
            m_data = '0; m_cnt = '0;
            evt_q.delete();
        end else begin
            evt = (evt_q.size() > 0) && (evt_q[0] == m_cycle);
            if (evt) void'(evt_q.pop_front());
            m_ovr = evt && m_fresh;
            if (!m_offer) begin
                w = first_from(m_ptr, req);
                if (m_fresh && w >= 0) begin
                    m_offer = 1; m_win = w; m_fresh = 0;
`ifdef RAND_SCHED_WHITEN_EN
                    m_data = randnum ^ m_cnt;
`else
                    m_data = randnum;
`endif
                end
            end else if (ack[m_win] || !req[m_win]) begin
                m_offer = 0;
                m_ptr   = (m_win + 1) % NREQ;
            end
            if (evt) m_fresh = 1;
            // Edge sampled now is usable SETTLE+1 clock edges later.
            if (frame_clk && !m_prev_fc) evt_q.push_back(m_cycle + SETTLE + 1);
            m_prev_fc = frame_clk;
            m_cnt     = m_cnt + 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        model_step();
        #1;
        chk("gnt", 32'(gnt), m_offer ? (32'd1 << m_win) : 32'd0);
        chk("rand_valid", 32'(rand_valid), 32'(m_offer));
        chk("rand_data", 32'(rand_data), 32'(m_data));
        chk("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    task automatic frame_pulse();
        frame_clk = 1'b1;
        tick();
        frame_clk = 1'b0;
    endtask

    task automatic wait_gnt(input int lim, output logic [NREQ-1:0] g);
        g = '0;
        for (int k = 0; k < lim && g == '0; k++) begin
            tick();
            g = gnt;
        end
    endtask

    logic [NREQ-1:0] g;
    logic [NREQ-1:0] s2_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [NREQ-1:0] acked;
    int              ovr_cnt, gnt_cnt, fc_cnt, r;

    initial begin
        Reset = 1'b1; frame_clk = 1'b0; req = '0; ack = '0; randnum = '0;
        m_cycle = 0;
        repeat (3) tick();
        Reset = 1'b0;
        tick();
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_valid", 32'(rand_valid), 32'd0);
        chk("reset_data", 32'(rand_data), 32'd0);

        // Single requester: exact latency, data and ack release.
        randnum = 3'b101; req = 4'b0001;
        frame_pulse();
        repeat (SETTLE + 1) tick();
        chk("s1_early", 32'(gnt), 32'd0);
        tick();
        chk("s1_gnt", 32'(gnt), 32'b0001);
        chk("s1_valid", 32'(rand_valid), 32'd1);
`ifndef RAND_SCHED_WHITEN_EN
        chk("s1_data", 32'(rand_data), 32'b101);
`endif
        ack = 4'b0001;
        tick();
        chk("s1_ack_drop", 32'(gnt), 32'd0);
        ack = '0; req = '0;
        tick();

        // Round robin across five frames from ptr=0.
        Reset = 1'b1; tick(); Reset = 1'b0; tick();
        req = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            frame_pulse();
            wait_gnt(20, g);
            chk($sformatf("s2_frame%0d", f), 32'(g), 32'(s2_exp[f]));
            ack = g; tick(); ack = '0; tick();
        end
        req = '0;
        tick();

        // Two unconsumed frames: one overrun, later requester gets the second value.
        ovr_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            frame_clk = (k == 0 || k == 8);
            randnum   = (k < 8) ? 3'b011 : 3'b010;
            tick();
            if (overrun === 1'b1) ovr_cnt++;
        end
        chk("s3_overrun_count", 32'(ovr_cnt), 32'd1);
        req = 4'b0010;
        wait_gnt(5, g);
        chk("s3_gnt", 32'(g), 32'b0010);
`ifndef RAND_SCHED_WHITEN_EN
        chk("s3_data", 32'(rand_data), 32'b010);
`endif
        ack = 4'b0010; tick(); ack = '0; req = '0; tick();

        // Abandon by requester 2; no regrant in the same frame; ptr moves to 3.
        req = 4'b0110;
        frame_pulse();
        wait_gnt(20, g);
        chk("s4_gnt", 32'(g), 32'b0100);
        req = 4'b0010;
        tick();
        chk("s4_abandon_gnt", 32'(gnt), 32'd0);
        chk("s4_abandon_valid", 32'(rand_valid), 32'd0);
        gnt_cnt = 0;
        repeat (10) begin
            tick();
            if (gnt !== '0) gnt_cnt++;
        end
        chk("s4_no_regrant", 32'(gnt_cnt), 32'd0);
        req = 4'b1110;
        frame_pulse();
        wait_gnt(20, g);
        chk("s4_ptr3", 32'(g), 32'b1000);
        ack = 4'b1000; tick(); ack = '0; req = '0; tick();

        // Reset in the middle of an offer.
        req = 4'b0001;
        frame_pulse();
        wait_gnt(20, g);
        chk("s5_gnt", 32'(g), 32'b0001);
        Reset = 1'b1;
        tick();
        chk("s5_reset_gnt", 32'(gnt), 32'd0);
        chk("s5_reset_valid", 32'(rand_valid), 32'd0);
        Reset = 1'b0;
        gnt_cnt = 0;
        repeat (12) begin
            tick();
            if (gnt !== '0) gnt_cnt++;
        end
        chk("s5_no_grant", 32'(gnt_cnt), 32'd0);
        frame_pulse();
        wait_gnt(20, g);
        chk("s5_regrant", 32'(g), 32'b0001);
        ack = 4'b0001; tick(); ack = '0; req = '0; tick();

        // Randomized traffic against the model.
        fc_cnt = 3;
        acked  = '0;
        for (int c = 0; c < 1500; c++) begin
            req   = req & ~acked;
            Reset = ($urandom_range(0, 299) == 0);
            if (fc_cnt == 0) begin
                frame_clk = ~frame_clk;
                fc_cnt    = $urandom_range(2, 12);
            end else begin
                fc_cnt--;
            end
            randnum = WIDTH'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i]) req[i] = ($urandom_range(0, 5) == 0);
                else if (!(m_offer && m_win == i)) req[i] = ($urandom_range(0, 9) != 0);
            end
            ack = NREQ'($urandom) & NREQ'($urandom);
            if (m_offer) begin
                ack[m_win] = 1'b0;
                r = $urandom_range(0, 9);
                if (r < 4) ack[m_win] = 1'b1;
                else if (r == 4) req[m_win] = 1'b0;
            end
            acked = (m_offer && ack[m_win]) ? (NREQ'(1) << m_win) : '0;
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rand_request_scheduler.md
# rand_request_scheduler

Shares the single 3-bit frame-rate random number generator among several game-logic consumers, such as enemy spawners and item droppers. The generator advances only once per frame, so two consumers reading it in the same frame would receive the same value. This block prevents that: each generated value is handed to at most one requester. Consumers are served round-robin, and every transfer completes with a grant/ack handshake.

## Interface
- NREQ, 4: number of requesters (2..8).
- WIDTH, 3: random value width; must match the generator output.
- SETTLE, 3: Clk cycles from a sampled frame_clk rising edge until the generator output is stable.

- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- frame_clk  in  1  frame tick, the same signal that drives the generator.
- randnum  in  WIDTH  generator output.
- req  in  NREQ  per-requester request level; held until acked or abandoned.
- ack  in  NREQ  per-requester acknowledge; only ack[winner] in OFFER counts.
- gnt  out  NREQ  one-hot grant, registered; all-zero outside OFFER.
- rand_valid  out  1  rand_data valid; high exactly in OFFER.
- rand_data  out  WIDTH  value latched for the current winner.
- overrun  out  1  one-cycle pulse when a new value arrives while the previous one is still unconsumed.

## Operation
- Edge/settle: frame_clk is registered once, and a rising edge is detected on the registered copy. The detection pulse is delayed SETTLE cycles to form fresh_evt.
- fresh flag:
  - set by fresh_evt;
  - cleared on the IDLE->OFFER transition, because the value is consumed at latch time;
  - if both occur in the same cycle, set wins.
- overrun pulses when fresh_evt arrives with fresh already 1.
- Round-robin pointer ptr (log2 NREQ bits): the search starts at ptr and wraps modulo NREQ.
- FSM states IDLE and OFFER:
  - IDLE: if fresh and any req bit is set, pick the first set req at or after ptr. Latch randnum into rand_data, set gnt[winner], clear fresh, go to OFFER.
  - IDLE with req=0 or fresh=0: stay, outputs idle.
  - OFFER, ack[winner]=1: ptr <= winner+1 (wrapping), clear gnt, go to IDLE.
  - OFFER, req[winner]=0 without ack (abandon): the value is discarded and fresh is not restored. ptr <= winner+1, go to IDLE.
  - OFFER: ack bits of non-winners are ignored, and changes to other req bits are ignored.
- rand_data holds its value throughout OFFER. It keeps its last value in IDLE, but is meaningful only while rand_valid=1.
- Reset, including mid-OFFER: state=IDLE, gnt=0, rand_valid=0, rand_data=0, overrun=0, fresh=0, ptr=0, and the settle pipeline is cleared. A frame edge in flight across reset is lost.

## Timing
- Latch latency: the cycle after IDLE sees fresh=1 with req!=0, gnt and rand_valid are high.
- A fresh_evt arriving in cycle t is visible as fresh in t+1. The earliest grant is therefore t+2.
- Ack sampled in cycle t causes gnt/rand_valid to drop in t+1.
- Back-to-back grants are impossible within one frame: one value allows one grant.
- Minimum transaction: 2 cycles (IDLE, OFFER).
- frame_clk to fresh: 1 + 1 + SETTLE cycles.

## Configuration
- RAND_SCHED_WHITEN_EN defined: a free-running WIDTH-bit Clk counter, reset to 0, is XORed with randnum at latch time. This decorrelates values handed to requesters that are served at different cycle offsets.
- RAND_SCHED_WHITEN_EN undefined: rand_data is the raw latched randnum, and the counter is not instantiated.

## Structure
- Package rand_sched_pkg holds:
  - the state enum {IDLE, OFFER};
  - the default NREQ/WIDTH/SETTLE constants;
  - a round-robin pick function (req vector, ptr) -> (found, index).
- Sub-module frame_tick_settle(Clk, Reset, frame_clk, fresh_evt) contains the frame_clk register, the edge detect, and the SETTLE-deep delay line.

## Test plan
- Reset, then one frame edge, with randnum=3'b101 and req=4'b0001:
  - gnt=0001 and rand_valid=1 at edge+SETTLE+3;
  - rand_data=101 (whitening off);
  - ack[0] drops gnt the next cycle.
- req=4'b1111 held over four frames, each acked immediately: grants in order 0001, 0010, 0100, 1000, then 0001 again on the fifth frame.
- Two frame edges with no requesters: overrun pulses once on the second fresh_evt. A later req=0010 receives the second value.
- In OFFER, requester 2 drops req without ack:
  - return to IDLE;
  - no further grant until the next frame even though req[1]=1;
  - ptr=3.
- Reset asserted during OFFER: the next cycle has gnt=0, rand_valid=0, and no grant until a new frame edge.
- With RAND_SCHED_WHITEN_EN, latch when the counter=3'b011 and randnum=3'b110: rand_data=101.
